// File: rtl/alu_pkg.sv
// Shared widths, opcode encoding and legality helper for the ALU issue path.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOT = 3'd4
    } alu_op_e;

    localparam logic [OP_W-1:0] ALU_OP_MAX = 3'd4;

    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return op > ALU_OP_MAX;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO holding packed commands ahead of the issue register.
module alu_cmd_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Command FIFO, registered ALU operand issue and response capture with flags.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int TAG_W = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int ENTRY_W = 2 * DATA_W + OP_W + TAG_W;

    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               issue_valid;
    logic [TAG_W-1:0]   issue_tag;
    logic               rsp_load;
    logic               issue_load;
    logic [DATA_W-1:0]  head_a;
    logic [DATA_W-1:0]  head_b;
    logic [OP_W-1:0]    head_op;
    logic [TAG_W-1:0]   head_tag;

    // Full blocks acceptance even when the head pops this cycle
    assign cmd_ready  = !fifo_full && rst_n;
    assign push       = cmd_valid && cmd_ready;
    assign fifo_din   = {cmd_a, cmd_b, cmd_op, cmd_tag};
    assign {head_a, head_b, head_op, head_tag} = fifo_dout;

    assign rsp_load   = issue_valid && (!rsp_valid || rsp_ready);
    assign issue_load = !fifo_empty && (!issue_valid || rsp_load);

    alu_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (issue_load),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            issue_tag   <= '0;
        end else if (issue_load) begin
            issue_valid <= 1'b1;
            alu_a       <= head_a;
            alu_b       <= head_b;
            alu_opcode  <= head_op;
            issue_tag   <= head_tag;
        end else if (rsp_load) begin
            issue_valid <= 1'b0;
        end
    end

    // Illegal opcodes flow through; the ALU yields 0 so zero and err both set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_tag    <= '0;
        end else if (rsp_load) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_zero   <= (alu_result == '0);
            rsp_err    <= op_illegal(alu_opcode);
            rsp_tag    <= issue_tag;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural ALU closing the loop.
module tb_alu_issue_queue;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] cmd_tag;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_err;
    logic [3:0] rsp_tag;
    logic [2:0] occupancy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(4), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .cmd_tag    (cmd_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .rsp_tag    (rsp_tag),
        .occupancy  (occupancy)
    );

    always_comb begin
        alu_result = 8'h00;
        case (alu_op_e'(alu_opcode))
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_NOT: alu_result = ~alu_a;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [3:0] tag);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
    endtask

    logic [3:0] got_tag [$];
    logic [7:0] got_res [$];
    int         acc;
    int         n;

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        send(8'h00, 8'h00, 3'd0, 4'd0);

        // reset held with cmd_valid asserted
        repeat (3) tick();
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);
        chk("rst_alu_opcode", alu_opcode, 0);
        chk("rst_rsp_result", rsp_result, 8'h00);
        chk("rst_rsp_flags", {rsp_zero, rsp_err}, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        cmd_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // single ADD: 2-cycle latency
        rsp_ready = 1'b1;
        send(8'h05, 8'h03, 3'd0, 4'd1);
        tick();
        cmd_valid = 1'b0;
        chk("single_occ_after_push", occupancy, 1);
        tick();
        chk("single_rsp_not_yet", rsp_valid, 0);
        chk("single_alu_a", alu_a, 8'h05);
        tick();
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_result", rsp_result, 8'h08);
        chk("single_flags", {rsp_zero, rsp_err}, 2'b00);
        chk("single_tag", rsp_tag, 1);
        tick();
        chk("single_rsp_cleared", rsp_valid, 0);

        // back-to-back stream
        send(8'h03, 8'h03, 3'd1, 4'd2);
        tick();
        send(8'h0F, 8'h00, 3'd4, 4'd3);
        tick();
        send(8'hF0, 8'h3C, 3'd2, 4'd4);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_r0_valid", rsp_valid, 1);
        chk("b2b_r0", {rsp_tag, rsp_result, rsp_zero}, {4'd2, 8'h00, 1'b1});
        tick();
        chk("b2b_r1", {rsp_valid, rsp_tag, rsp_result, rsp_zero}, {1'b1, 4'd3, 8'hF0, 1'b0});
        tick();
        chk("b2b_r2", {rsp_valid, rsp_tag, rsp_result, rsp_zero}, {1'b1, 4'd4, 8'h30, 1'b0});
        tick();
        chk("b2b_drained", rsp_valid, 0);

        // backpressure: 10 offers, DEPTH+2 fit
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            send(8'(i), 8'h10, 3'd0, 4'(i));
            @(negedge clk);
            if (cmd_ready) acc++;
            tick();
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", acc, 6);
        chk("bp_cmd_ready_low", cmd_ready, 0);
        chk("bp_occupancy", occupancy, 4);
        chk("bp_stall_rsp", {rsp_valid, rsp_tag, rsp_result}, {1'b1, 4'd0, 8'h10});
        chk("bp_stall_alu_a", alu_a, 8'h01);

        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got_tag.push_back(rsp_tag);
                got_res.push_back(rsp_result);
            end
            tick();
        end
        chk("bp_rsp_count", got_tag.size(), 6);
        for (int i = 0; i < got_tag.size() && i < 6; i++) begin
            chk($sformatf("bp_rsp%0d_tag", i), got_tag[i], i);
            chk($sformatf("bp_rsp%0d_res", i), got_res[i], 8'h10 + i);
        end
        chk("bp_occ_drained", occupancy, 0);

        // illegal opcode
        send(8'hFF, 8'h00, 3'b110, 4'd7);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("ill_valid", rsp_valid, 1);
        chk("ill_result", rsp_result, 8'h00);
        chk("ill_err_zero", {rsp_err, rsp_zero}, 2'b11);
        chk("ill_tag", rsp_tag, 7);
        chk("ill_alu_hold", {alu_a, alu_opcode}, {8'hFF, 3'b110});
        tick();

        // asynchronous reset mid-stream
        rsp_ready = 1'b0;
        send(8'h11, 8'h01, 3'd0, 4'd1);
        tick();
        send(8'h22, 8'h01, 3'd0, 4'd2);
        tick();
        send(8'h33, 8'h01, 3'd0, 4'd3);
        tick();
        cmd_valid = 1'b0;
        chk("ar_pre_state", {rsp_valid, occupancy}, {1'b1, 3'd1});
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_occupancy", occupancy, 0);
        chk("ar_cmd_ready", cmd_ready, 0);
        chk("ar_alu", {alu_a, alu_b, alu_opcode}, 0);
        chk("ar_rsp_regs", {rsp_result, rsp_tag, rsp_zero, rsp_err}, 0);
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("ar_release_ready", cmd_ready, 1);
        send(8'h0A, 8'h50, 3'd3, 4'd9);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk("ar_first_rsp_seen", rsp_valid, 1);
        chk("ar_first_rsp", {rsp_tag, rsp_result, rsp_err}, {4'd9, 8'h5A, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Command buffer and issue stage placed directly upstream of the 8-bit combinational ALU. It accepts operand/opcode commands over a valid/ready handshake and queues them in a small FIFO. It drives registered operands into the ALU and captures the ALU result, together with status flags and a pass-through tag, into a response register with its own valid/ready handshake.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- TAG_W, 4, width of the caller tag carried with each command
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept a command
- cmd_a  input  8  operand A
- cmd_b  input  8  operand B
- cmd_op  input  3  opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT A, 5–7 illegal)
- cmd_tag  input  TAG_W  caller tag
- alu_a  output  8  registered operand A to ALU
- alu_b  output  8  registered operand B to ALU
- alu_opcode  output  3  registered opcode to ALU
- alu_result  input  8  combinational ALU result for alu_a/alu_b/alu_opcode
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  8  captured result
- rsp_zero  output  1  rsp_result == 0
- rsp_err  output  1  command had illegal opcode (5–7)
- rsp_tag  output  TAG_W  tag of the command
- occupancy  output  $clog2(DEPTH+1)  FIFO entry count

## Operation
- Three stages: FIFO → issue register (issue_valid, alu_a/b/opcode, tag) → response register.
- Push: cmd_valid && cmd_ready. cmd_ready = (occupancy < DEPTH) && rst_n. No pass-through at full: cmd_ready stays low when full even if a pop occurs in the same cycle.
- rsp_load = issue_valid && (!rsp_valid || rsp_ready).
- issue_load = fifo_nonempty && (!issue_valid || rsp_load); pops FIFO head into issue register.
- issue_valid clears when rsp_load occurs without issue_load; alu_a/b/opcode then hold their last values.
- On rsp_load: rsp_result = alu_result, rsp_zero = (alu_result == 0), rsp_err = (alu_opcode > 4), rsp_tag = issue tag. Illegal opcodes pass through; the ALU returns 0 for them, so rsp_err = 1 and rsp_zero = 1.
- rsp_valid clears on rsp_ready when no new rsp_load occurs.
- Order is strictly FIFO. Total buffering is DEPTH+2 commands.
- Simultaneous push and pop: occupancy unchanged, both take effect. Pointers wrap modulo DEPTH.
- Reset (asynchronous, any time, including mid-stream): all queued and in-flight commands are discarded; no response is produced for them.

## Timing
- Reset values: cmd_ready 0 while rst_n low, 1 after release. rsp_valid 0, rsp_result 0, rsp_zero 0, rsp_err 0, rsp_tag 0, alu_a 0, alu_b 0, alu_opcode 0, occupancy 0, issue_valid 0.
- Latency, empty pipeline: command accepted at edge t0 → issue register loaded at t1 → rsp_valid high after t2 (2 cycles).
- Throughput: 1 command/cycle while rsp_ready is held high.
- Stall (rsp_valid && !rsp_ready): response, issue register and ALU inputs stay stable. The FIFO fills; cmd_ready drops once occupancy == DEPTH.
- occupancy updates on the edge of the push/pop.

## Structure
- Package alu_pkg: DATA_W = 8, OP_W = 3, opcode enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT), constant ALU_OP_MAX = 4.
- One sub-module: alu_cmd_fifo, a synchronous FIFO parameterised by width and DEPTH, with push/pop/full/empty/count ports. Issue and response logic stays in the top module.

## Test plan
- Reset: hold rst_n low 3 cycles with cmd_valid = 1 → cmd_ready 0, rsp_valid 0, occupancy 0, alu_a/alu_b/alu_opcode 0x00/0x00/0.
- Single command A=0x05, B=0x03, op=0, tag=1, with rsp_ready=1 → two cycles after acceptance: rsp_valid 1, rsp_result 0x08, zero 0, err 0, tag 1.
- Back-to-back stream, rsp_ready=1: SUB 0x03−0x03, NOT 0x0F, AND 0xF0&0x3C, tags 2,3,4 → consecutive responses 0x00 (zero=1), 0xF0, 0x30, in tag order, one per cycle.
- Backpressure: rsp_ready=0, offer 10 commands with tags 0–9 → exactly 6 accepted (DEPTH+2), cmd_ready low, occupancy 4. Then release rsp_ready → responses for tags 0–5 in order, no loss or duplication.
- Illegal opcode 3'b110 with A=0xFF → rsp_result 0x00, rsp_err 1, rsp_zero 1.
- Assert rst_n low asynchronously (mid-cycle) with 3 commands queued → outputs go to reset values immediately. After release, a new command (OR 0x0A|0x50) yields 0x5A as the first response.
